// File: rtl/cubic_row_sequencer_if.sv
// Bundle of the scaler-control, line-memory, engine and destination-memory
// signals of cubic_row_sequencer.
//   master: the environment (scaler FSM, SRAM, engine) driving start/params,
//           rd_data and eng_out.
//   slave : the sequencer; drives busy/done, read strobe/address, engine
//           controls and the destination write.
interface cubic_row_sequencer_if #(
  parameter int unsigned AW = 14,
  parameter int unsigned IW = 8
);
  // job request
  logic          start;
  logic [AW-1:0] src_base;
  logic [IW:0]   src_len;
  logic [IW+7:0] start_pos;
  logic [IW+7:0] step;
  logic [IW:0]   n_out;
  logic [AW-1:0] dst_base;
  logic          busy;
  logic          done;
  // source line memory
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  // engine
  logic [2:0]    eng_cycle_cnt;
  logic [23:0]   eng_x;
  logic [7:0]    eng_p;
  logic [7:0]    eng_out;
  // destination memory
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (
    output start, src_base, src_len, start_pos, step, n_out, dst_base,
    output rd_data, eng_out,
    input  busy, done, rd_en, rd_addr, eng_cycle_cnt, eng_x, eng_p,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, src_base, src_len, start_pos, step, n_out, dst_base,
    input  rd_data, eng_out,
    output busy, done, rd_en, rd_addr, eng_cycle_cnt, eng_x, eng_p,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/cubic_row_sequencer.sv
// Walks one cubic-interpolation engine along a source row: per output sample
// it issues four clamped neighbour reads, drives the engine phase/weights and
// writes the previous engine result to the destination memory.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        cubic_row_sequencer_if.slave: start/params, busy/done,
//              rd_en/rd_addr/rd_data, eng_cycle_cnt/eng_x/eng_p/eng_out,
//              wr_en/wr_addr/wr_data
module cubic_row_sequencer #(
  parameter int unsigned AW = 14,
  parameter int unsigned IW = 8
) (
  input logic                  clk,
  input logic                  rst,
  cubic_row_sequencer_if.slave bus
);

  localparam int unsigned PW = IW + 9;  // position width, Q(IW+1).8
  localparam int unsigned CW = IW + 1;  // count / length width
  localparam int unsigned NW = IW + 3;  // signed neighbour index width
  localparam int unsigned SW = IW + 8;  // step width

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ph_q, ph_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] grp_q, grp_d;
  logic [AW-1:0] src_base_q, src_base_d;
  logic [CW-1:0] src_len_q, src_len_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] n_out_q, n_out_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [23:0]   eng_x_q, eng_x_d;

  // saturating position advance
  logic [PW:0] pos_sum;
  assign pos_sum = PW'(pos_q) + (PW+1)'(step_q) + (PW+1)'(0);

  // intermediates of the next-state block
  logic [NW-1:0]        nb_raw, nb_cl;
  logic signed [NW-1:0] nb_s, hi_s;
  logic [15:0]          sq, cu;
  logic [7:0]           t, t2, t3;

  // next state, job registers and registered outputs
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    pos_d      = pos_q;
    grp_d      = grp_q;
    src_base_d = src_base_q;
    src_len_d  = src_len_q;
    step_d     = step_q;
    n_out_d    = n_out_q;
    // write address advances after each write so it always reads dst_base+g
    wr_addr_d  = wr_en_q ? wr_addr_q + AW'(1) : wr_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_base_d = bus.src_base;
          src_len_d  = bus.src_len;
          step_d     = bus.step;
          n_out_d    = bus.n_out;
          pos_d      = PW'(bus.start_pos);
          grp_d      = '0;
          ph_d       = '0;
          wr_addr_d  = bus.dst_base;
          state_d    = (bus.n_out == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (ph_q == 3'd4) begin
          pos_d = pos_sum[PW] ? '1 : pos_sum[PW-1:0];
          ph_d  = '0;
          if (grp_q == n_out_q - CW'(1)) state_d = S_FLUSH;
          else                           grp_d   = grp_q + CW'(1);
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_FLUSH: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // neighbour index i+ph-1 clamped to [0, src_len-1]
    nb_raw = NW'(pos_d[PW-1:8]) + NW'(ph_d) - NW'(1);
    nb_s   = signed'(nb_raw);
    hi_s   = signed'(NW'(src_len_d) - NW'(1));
    if (nb_s < 0)         nb_cl = '0;
    else if (nb_s > hi_s) nb_cl = hi_s;
    else                  nb_cl = nb_raw;

    // rounded powers of the fractional part
    t  = pos_d[7:0];
    sq = 16'(t) * 16'(t) + 16'd128;
    t2 = 8'(sq >> 8);
    cu = 16'(t2) * 16'(t) + 16'd128;
    t3 = 8'(cu >> 8);

    // outputs describe the state being entered
    busy_d    = state_d inside {S_RUN, S_FLUSH, S_WRITE};
    done_d    = (state_d == S_DONE);
    cnt_d     = (state_d == S_RUN) ? ph_d : 3'd0;
    rd_en_d   = (state_d == S_RUN) && (ph_d != 3'd4);
    wr_en_d   = ((state_d == S_RUN) && (ph_d == 3'd1) && (grp_d != '0)) ||
                (state_d == S_WRITE);
    rd_addr_d = rd_en_d ? src_base_d + AW'(nb_cl) : rd_addr_q;
    eng_x_d   = {t, t2, t3};
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      pos_q      <= '0;
      grp_q      <= '0;
      src_base_q <= '0;
      src_len_q  <= '0;
      step_q     <= '0;
      n_out_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      cnt_q      <= '0;
      eng_x_q    <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      pos_q      <= pos_d;
      grp_q      <= grp_d;
      src_base_q <= src_base_d;
      src_len_q  <= src_len_d;
      step_q     <= step_d;
      n_out_q    <= n_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      cnt_q      <= cnt_d;
      eng_x_q    <= eng_x_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.eng_cycle_cnt = cnt_q;
  assign bus.eng_x         = eng_x_q;
  assign bus.eng_p         = bus.rd_data;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = bus.eng_out;

endmodule

// File: tb/tb_cubic_row_sequencer.sv
// Scoreboard bench for cubic_row_sequencer: directed jobs push expected
// reads, weights, writes and done pulses; a negedge monitor pops and compares.
module tb_cubic_row_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cubic_row_sequencer_if #(.AW(14), .IW(8)) bus ();

  cubic_row_sequencer #(.AW(14), .IW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; logic [13:0] addr; logic [2:0] cnt; } rd_t;
  typedef struct { int cyc; logic [23:0] x; } x_t;
  typedef struct { int cyc; logic [13:0] addr; logic [7:0] data; } wr_t;

  rd_t rd_q[$];
  x_t  x_q[$];
  wr_t wr_q[$];
  int  dn_q[$];

  function automatic logic [7:0] mem(input logic [13:0] a);
    return a[7:0] ^ 8'h5A ^ {a[11:8], 4'h0} ^ {6'h0, a[13:12]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // synchronous source memory
  initial bus.rd_data = 8'h00;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem(bus.rd_addr);

  // engine stand-in: collects pixels in phases 1..4, result = byte sum
  logic [7:0] p [4];
  initial begin
    bus.eng_out = 8'h00;
    for (int k = 0; k < 4; k++) p[k] = 8'h00;
  end
  always @(posedge clk) begin
    if (bus.eng_cycle_cnt == 3'd0) bus.eng_out <= p[0] + p[1] + p[2] + p[3];
    else if (bus.eng_cycle_cnt <= 3'd4) p[2'(bus.eng_cycle_cnt - 3'd1)] <= bus.eng_p;
  end

  // monitor
  rd_t m_r;
  x_t  m_x;
  wr_t m_w;
  int  m_d;
  always @(negedge clk) begin
    if (bus.rd_en) begin
      if (rd_q.size() == 0) chk("rd unexpected", 32'(bus.rd_en), 0);
      else begin
        m_r = rd_q.pop_front();
        chk("rd cycle", cyc, m_r.cyc);
        chk("rd addr", 32'(bus.rd_addr), 32'(m_r.addr));
        chk("rd cnt", 32'(bus.eng_cycle_cnt), 32'(m_r.cnt));
      end
      if (bus.eng_cycle_cnt == 3'd0) begin
        if (x_q.size() == 0) chk("ph0 unexpected", 32'(bus.rd_en), 0);
        else begin
          m_x = x_q.pop_front();
          chk("eng_x cycle", cyc, m_x.cyc);
          chk("eng_x", 32'(bus.eng_x), 32'(m_x.x));
        end
      end
    end
    if (bus.wr_en) begin
      if (wr_q.size() == 0) chk("wr unexpected", 32'(bus.wr_en), 0);
      else begin
        m_w = wr_q.pop_front();
        chk("wr cycle", cyc, m_w.cyc);
        chk("wr addr", 32'(bus.wr_addr), 32'(m_w.addr));
        chk("wr data", 32'(bus.wr_data), 32'(m_w.data));
        chk("busy at wr", 32'(bus.busy), 1);
      end
    end
    if (bus.done) begin
      if (dn_q.size() == 0) chk("done unexpected", 32'(bus.done), 0);
      else begin
        m_d = dn_q.pop_front();
        chk("done cycle", cyc, m_d);
        chk("busy at done", 32'(bus.busy), 0);
      end
    end
  end

  task automatic start_job(input logic [13:0] sb, input logic [8:0] sl,
                           input logic [15:0] sp, input logic [15:0] st,
                           input logic [8:0] no, input logic [13:0] db,
                           output int t0);
    @(posedge clk); #1;
    bus.src_base = sb; bus.src_len = sl; bus.start_pos = sp;
    bus.step = st; bus.n_out = no; bus.dst_base = db;
    bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // expectations for one group: four reads, ph0 weights, optional write
  task automatic push_group(input int t0, input int g,
                            input logic [13:0] a0, input logic [13:0] a1,
                            input logic [13:0] a2, input logic [13:0] a3,
                            input logic [23:0] x, input logic [13:0] db,
                            input bit do_wr);
    logic [13:0] a [4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int k = 0; k < 4; k++) rd_q.push_back('{t0 + 1 + 5*g + k, a[k], 3'(k)});
    x_q.push_back('{t0 + 1 + 5*g, x});
    if (do_wr)
      wr_q.push_back('{t0 + 7 + 5*g, db + 14'(g),
                       mem(a0) + mem(a1) + mem(a2) + mem(a3)});
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((rd_q.size() + x_q.size() + wr_q.size() + dn_q.size()) != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk({nm, " pending"}, 32'(rd_q.size() + x_q.size() + wr_q.size() + dn_q.size()), 0);
    rd_q.delete(); x_q.delete(); wr_q.delete(); dn_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " busy"},    32'(bus.busy), 0);
    chk({nm, " done"},    32'(bus.done), 0);
    chk({nm, " rd_en"},   32'(bus.rd_en), 0);
    chk({nm, " wr_en"},   32'(bus.wr_en), 0);
    chk({nm, " rd_addr"}, 32'(bus.rd_addr), 0);
    chk({nm, " wr_addr"}, 32'(bus.wr_addr), 0);
    chk({nm, " cnt"},     32'(bus.eng_cycle_cnt), 0);
    chk({nm, " eng_x"},   32'(bus.eng_x), 0);
  endtask

  int t0;

  initial begin
    bus.start = 1'b0; bus.src_base = '0; bus.src_len = '0; bus.start_pos = '0;
    bus.step = '0; bus.n_out = '0; bus.dst_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // basic single sample, t=0.5
    start_job(14'h100, 9'd16, 16'h0180, 16'h0100, 9'd1, 14'h200, t0);
    push_group(t0, 0, 14'h100, 14'h101, 14'h102, 14'h103, 24'h804020, 14'h200, 1'b1);
    dn_q.push_back(t0 + 8);
    drain("basic");

    // left edge clamp
    start_job(14'h300, 9'd16, 16'h0040, 16'h0100, 9'd1, 14'h210, t0);
    push_group(t0, 0, 14'h300, 14'h300, 14'h301, 14'h302, 24'h401004, 14'h210, 1'b1);
    dn_q.push_back(t0 + 8);
    drain("left");

    // right edge clamp
    start_job(14'h400, 9'd4, 16'h0300, 16'h0100, 9'd1, 14'h220, t0);
    push_group(t0, 0, 14'h402, 14'h403, 14'h403, 14'h403, 24'h000000, 14'h220, 1'b1);
    dn_q.push_back(t0 + 8);
    drain("right");

    // three samples, half step; second start mid-job must be ignored
    start_job(14'h100, 9'd16, 16'h0180, 16'h0080, 9'd3, 14'h230, t0);
    push_group(t0, 0, 14'h100, 14'h101, 14'h102, 14'h103, 24'h804020, 14'h230, 1'b1);
    push_group(t0, 1, 14'h101, 14'h102, 14'h103, 14'h104, 24'h000000, 14'h230, 1'b1);
    push_group(t0, 2, 14'h101, 14'h102, 14'h103, 14'h104, 24'h804020, 14'h230, 1'b1);
    dn_q.push_back(t0 + 18);
    repeat (4) @(posedge clk);
    #1;
    bus.src_base = 14'h700; bus.n_out = 9'd1; bus.dst_base = 14'h3F0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain("multi");

    // empty job
    start_job(14'h100, 9'd16, 16'h0180, 16'h0100, 9'd0, 14'h240, t0);
    dn_q.push_back(t0 + 1);
    drain("empty");

    // reset in the middle of a four-sample job
    start_job(14'h500, 9'd16, 16'h0000, 16'h0100, 9'd4, 14'h250, t0);
    push_group(t0, 0, 14'h500, 14'h500, 14'h501, 14'h502, 24'h000000, 14'h250, 1'b1);
    for (int k = 0; k < 4; k++) rd_q.push_back('{t0 + 6 + k, 14'h500 + 14'(k), 3'(k)});
    x_q.push_back('{t0 + 6, 24'h000000});
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    drain("pre-reset");
    repeat (40) @(posedge clk);

    // a job after the abandoned one runs normally
    start_job(14'h100, 9'd16, 16'h0180, 16'h0100, 9'd1, 14'h260, t0);
    push_group(t0, 0, 14'h100, 14'h101, 14'h102, 14'h103, 24'h804020, 14'h260, 1'b1);
    dn_q.push_back(t0 + 8);
    drain("after-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
